// File: rtl/pmod_button_reader.sv
// PMOD button reader: synchronize, debounce, queue press/release events.
// Define LONG_PRESS_EN to add per-channel long-press (type 10) events.
module pmod_button_reader #(
  parameter int N_BTN           = 6,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int FIFO_DEPTH      = 8,
  parameter int LONG_CYCLES     = 27000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_state,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [4:0]       evt_data,
  output logic             overflow,
  input  logic             clear_ovf
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] long_set;

  logic [N_BTN-1:0] rel_p;
  logic [N_BTN-1:0] prs_p;
  logic [N_BTN-1:0] lng_p;
  logic [N_BTN-1:0] clr_rel;
  logic [N_BTN-1:0] clr_prs;
  logic [N_BTN-1:0] clr_lng;

  logic       sel_valid;
  logic [2:0] sel_idx;
  logic [1:0] sel_type;
  logic       push_ok;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic       dup;

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [4:0]  mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic          st;
    logic [CW-1:0] cnt;
    logic          flip;

    assign flip = (sync2[g] != st) &&
                  (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st  <= 1'b0;
        cnt <= '0;
      end else if (sync2[g] == st) begin
        cnt <= '0;
      end else if (flip) begin
        st  <= sync2[g];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign btn_state[g] = st;
    assign rise[g]      = flip & sync2[g];
    assign fall[g]      = flip & ~sync2[g];

`ifdef LONG_PRESS_EN
    localparam int LW = $clog2(LONG_CYCLES);
    logic [LW-1:0] hold;

    // Saturates at the top so each press fires only once.
    always_ff @(posedge clk) begin
      if (!rst_n || !st) begin
        hold <= '0;
      end else if (hold != LW'(LONG_CYCLES - 1)) begin
        hold <= hold + 1'b1;
      end
    end

    assign long_set[g] = st && (hold == LW'(LONG_CYCLES - 2));
`else
    assign long_set[g] = 1'b0;
`endif
  end

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign pop   = !empty && evt_ready;
  assign push_ok = !full || pop;
  assign push  = sel_valid && push_ok;

  // Lowest channel wins; within a channel release, press, long.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_type  = '0;
    clr_rel   = '0;
    clr_prs   = '0;
    clr_lng   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (!sel_valid && (rel_p[i] || prs_p[i] || lng_p[i])) begin
        sel_valid = 1'b1;
        sel_idx   = 3'(i);
        if (rel_p[i]) begin
          sel_type   = 2'b00;
          clr_rel[i] = push_ok;
        end else if (prs_p[i]) begin
          sel_type   = 2'b01;
          clr_prs[i] = push_ok;
        end else begin
          sel_type   = 2'b10;
          clr_lng[i] = push_ok;
        end
      end
    end
  end

  assign dup = |((rel_p & ~clr_rel & fall) |
                 (prs_p & ~clr_prs & rise) |
                 (lng_p & ~clr_lng & long_set));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rel_p    <= '0;
      prs_p    <= '0;
      lng_p    <= '0;
      overflow <= 1'b0;
    end else begin
      rel_p    <= (rel_p & ~clr_rel) | fall;
      prs_p    <= (prs_p & ~clr_prs) | rise;
      lng_p    <= (lng_p & ~clr_lng) | long_set;
      overflow <= dup | (overflow & ~clear_ovf);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {sel_type, sel_idx};
  end

  assign evt_valid = !empty;
  assign evt_data  = evt_valid ? mem[rd_ptr[AW-1:0]] : 5'd0;

endmodule

// File: doc/pmod_button_reader.md
PMOD_BUTTON_READER -- requirements
Module: pmod_button_reader

Interface
REQ-001 Parameter N_BTN, default 6, number of PMOD button inputs (1..8).
REQ-002 Parameter DEBOUNCE_CYCLES, default 270000, consecutive stable cycles required to accept a new level (10 ms at 27 MHz); legal range 2..2^20.
REQ-003 Parameter FIFO_DEPTH, default 8, event FIFO entries (power of two, 2..32).
REQ-004 Parameter LONG_CYCLES, default 27000000, held-press cycles before a long-press event (used only when LONG_PRESS_EN is defined).
REQ-005 clk  input  1  system clock (~27 MHz, supplied by ESP32).
REQ-006 rst_n  input  1  reset; synchronous, active-low.
REQ-007 btn_in  input  N_BTN  raw PMOD button levels; asynchronous to clk; 1 = pressed.
REQ-008 btn_state  output  N_BTN  debounced levels.
REQ-009 evt_valid  output  1  event FIFO not empty.
REQ-010 evt_ready  input  1  consumer accepts the head event when evt_valid and evt_ready are both high.
REQ-011 evt_data  output  5  {type[1:0], index[2:0]}; type 00 = release, 01 = press, 10 = long press, 11 = reserved.
REQ-012 overflow  output  1  sticky flag: an event was lost.
REQ-013 clear_ovf  input  1  single-cycle pulse that clears overflow.

Function
REQ-014 Each btn_in bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 Per channel: counter increments while synchronized level != btn_state[i]; counter clears whenever the levels are equal.
REQ-016 When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, btn_state[i] SHALL update on that edge and the counter SHALL clear; a clean step therefore reaches btn_state exactly DEBOUNCE_CYCLES+2 cycles after btn_in.
REQ-017 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change btn_state or generate events.
REQ-018 A btn_state 0->1 change SHALL set pending_press[i]; a 1->0 change SHALL set pending_release[i], on the same edge.
REQ-019 Arbiter: at most one pending event is pushed per cycle, lowest channel index first; for a channel, release before press before long; the pushed pending bit clears on the same edge.
REQ-020 Push occurs only when the FIFO is not full, or when it is full and a pop happens in the same cycle (simultaneous push and pop SHALL both succeed).
REQ-021 Pending bits wait while the FIFO is full; a pending bit set again while already set SHALL set overflow and drop the duplicate.
REQ-022 With an empty FIFO and no other pending events, evt_valid SHALL rise one cycle after the btn_state change.
REQ-023 evt_data SHALL hold the head entry and stay stable while evt_valid=1 and evt_ready=0; FIFO order is first-in first-out.
REQ-024 evt_ready while evt_valid=0 SHALL have no effect.
REQ-025 overflow SHALL stay set until clear_ovf; if a set and a clear coincide, set wins.

Reset
REQ-026 While rst_n=0 at a clk edge: synchronizers, btn_state, counters, pending bits, FIFO pointers and overflow SHALL clear to 0; evt_valid=0, evt_data=0.
REQ-027 Reset mid-operation SHALL discard queued and pending events; a button held across reset SHALL produce a press event after DEBOUNCE_CYCLES+2 cycles once rst_n=1.

Configuration
REQ-028 Macro LONG_PRESS_EN defined: a per-channel hold counter runs while btn_state[i]=1; on reaching LONG_CYCLES-1 it SHALL set pending_long[i] exactly once per press; the counter clears on release.
REQ-029 Macro LONG_PRESS_EN undefined: no hold counters are built, type 10 is never produced, and all other behaviour is identical.

Verification (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, LONG_CYCLES=16)
REQ-030 btn_in[2] step 0->1 held -> btn_state[2]=1 six cycles later; evt_data=5'b01_010 valid on the next cycle; held with evt_ready=1 it is consumed after one cycle.
REQ-031 btn_in[0] pulsed high for 3 cycles -> btn_state and evt_valid remain 0.
REQ-032 btn_in[1] and btn_in[4] rise on the same cycle -> events 01_001 then 01_100, in that order, on consecutive cycles.
REQ-033 evt_ready=0, 6 press/release events generated -> 4 queued, 2 pending; repeat press on a pending channel -> overflow=1; clear_ovf pulse -> overflow=0.
REQ-034 LONG_PRESS_EN defined, btn_in[3] held 40 cycles -> events 01_011, then a single 10_011; after release, 00_011.
REQ-035 rst_n=0 for one cycle with 3 events queued -> evt_valid=0 and overflow=0 on the next cycle.
